// File: rtl/memory_turn_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : memory_turn_scoreboard
// Description : N-player turn, BCD turn timer, BCD score and winner controller
//               for the memory card game.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_turn_scoreboard #(
    parameter int NUM_PLAYERS  = 2,
    parameter int TOTAL_PAIRS  = 8,
    parameter int TURN_SECONDS = 15,
    parameter int CLK_HZ       = 25000000,
    parameter int PW           = ($clog2(NUM_PLAYERS) > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     match_valid,
    input  logic                     match_hit,
    output logic [PW-1:0]            cur_player,
    output logic [3:0]               timer_tens,
    output logic [3:0]               timer_units,
    output logic [8*NUM_PLAYERS-1:0] scores_bcd,
    output logic [6:0]               pairs_found,
    output logic                     turn_timeout,
    output logic                     game_done,
    output logic                     result_valid,
    output logic [PW-1:0]            winner,
    output logic                     tie
);

    localparam int              PSW           = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PSW-1:0]  c_PRESC_MAX   = PSW'(CLK_HZ - 1);
    localparam logic [PW-1:0]   c_LAST_PLAYER = PW'(NUM_PLAYERS - 1);
    localparam logic [3:0]      c_TENS        = 4'(TURN_SECONDS / 10);
    localparam logic [3:0]      c_UNITS       = 4'(TURN_SECONDS % 10);
    localparam logic [6:0]      c_TOTAL       = 7'(TOTAL_PAIRS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_cur_player;
    logic [PW-1:0]   r_winner;
    logic [PW-1:0]   r_scan_idx;
    logic [3:0]      r_tens;
    logic [3:0]      r_units;
    logic [7:0]      r_scores [NUM_PLAYERS];
    logic [7:0]      r_max;
    logic [6:0]      r_pairs;
    logic [PSW-1:0]  r_presc;
    logic            r_turn_timeout;
    logic            r_tie;
    logic            r_result_valid;

    logic            w_sec_tick;
    logic            w_new_game;
    logic            w_timer_zero;
    logic [PW-1:0]   w_next_player;
    logic [7:0]      w_cur_score;
    logic [7:0]      w_score_inc;

    assign w_sec_tick    = (r_state == ST_PLAY) && (r_presc == c_PRESC_MAX);
    assign w_new_game    = start && (r_state != ST_PLAY);
    assign w_timer_zero  = (r_tens == 4'd0) && (r_units == 4'd0);
    assign w_next_player = (r_cur_player == c_LAST_PLAYER) ? '0 : r_cur_player + 1'b1;
    assign w_cur_score   = r_scores[r_cur_player];

    // BCD increment of the active player's score, saturating at 99
    always_comb begin
        w_score_inc = w_cur_score;
        if (w_cur_score == 8'h99) begin
            w_score_inc = w_cur_score;
        end else if (w_cur_score[3:0] == 4'd9) begin
            w_score_inc = {w_cur_score[7:4] + 4'd1, 4'd0};
        end else begin
            w_score_inc = {w_cur_score[7:4], w_cur_score[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cur_player   <= '0;
            r_winner       <= '0;
            r_scan_idx     <= '0;
            r_tens         <= c_TENS;
            r_units        <= c_UNITS;
            r_max          <= '0;
            r_pairs        <= '0;
            r_presc        <= '0;
            r_turn_timeout <= 1'b0;
            r_tie          <= 1'b0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
        end else begin
            r_turn_timeout <= 1'b0;
            if (w_new_game) begin
                r_state        <= ST_PLAY;
                r_cur_player   <= '0;
                r_tens         <= c_TENS;
                r_units        <= c_UNITS;
                r_pairs        <= '0;
                r_presc        <= '0;
                r_winner       <= '0;
                r_tie          <= 1'b0;
                r_result_valid <= 1'b0;
                for (int i = 0; i < NUM_PLAYERS; i++) r_scores[i] <= '0;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        // A resolved match outranks a coincident second tick
                        if (match_valid) begin
                            r_presc <= '0;
                            if (match_hit) begin
                                r_scores[r_cur_player] <= w_score_inc;
                                r_pairs                <= r_pairs + 7'd1;
                                if (r_pairs + 7'd1 == c_TOTAL) begin
                                    r_state        <= ST_DONE;
                                    r_scan_idx     <= '0;
                                    r_winner       <= '0;
                                    r_tie          <= 1'b0;
                                    r_result_valid <= 1'b0;
                                end else begin
                                    r_tens  <= c_TENS;
                                    r_units <= c_UNITS;
                                end
                            end else begin
                                r_cur_player <= w_next_player;
                                r_tens       <= c_TENS;
                                r_units      <= c_UNITS;
                            end
                        end else if (w_sec_tick) begin
                            r_presc <= '0;
                            if (w_timer_zero) begin
                                r_cur_player   <= w_next_player;
                                r_tens         <= c_TENS;
                                r_units        <= c_UNITS;
                                r_turn_timeout <= 1'b1;
                            end else if (r_units == 4'd0) begin
                                r_tens  <= r_tens - 4'd1;
                                r_units <= 4'd9;
                            end else begin
                                r_units <= r_units - 4'd1;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        // Index 0 loads the running max; later indices compare
                        if (!r_result_valid) begin
                            if (r_scan_idx == '0) begin
                                r_max      <= r_scores[0];
                                r_scan_idx <= PW'(1);
                            end else begin
                                if (r_scores[r_scan_idx] > r_max) begin
                                    r_max    <= r_scores[r_scan_idx];
                                    r_winner <= r_scan_idx;
                                    r_tie    <= 1'b0;
                                end else if (r_scores[r_scan_idx] == r_max) begin
                                    r_tie <= 1'b1;
                                end
                                if (r_scan_idx == c_LAST_PLAYER) begin
                                    r_result_valid <= 1'b1;
                                end else begin
                                    r_scan_idx <= r_scan_idx + 1'b1;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_scores
            assign scores_bcd[8*gi +: 8] = r_scores[gi];
        end
    endgenerate

    assign cur_player   = r_cur_player;
    assign timer_tens   = r_tens;
    assign timer_units  = r_units;
    assign pairs_found  = r_pairs;
    assign turn_timeout = r_turn_timeout;
    assign game_done    = (r_state == ST_DONE);
    assign result_valid = r_result_valid;
    assign winner       = r_winner;
    assign tie          = r_tie;

endmodule
`default_nettype wire

// File: doc/memory_turn_scoreboard.md
Name: memory_turn_scoreboard

Overview:
Parametrised turn and score controller for the memory card game, the N-player successor to the fixed two-player pair counter and global seconds timer. It tracks the active player and runs a per-turn countdown with timeout-driven turn passing. It keeps per-player BCD pair scores, detects end of game and scans for the winner and tie. All outputs are BCD nibbles so they feed the existing seven-segment decoders directly, and it runs on the VGA-domain clock alongside the memory board logic.

Parameters:
NUM_PLAYERS, 2, number of players; legal range 2..4; PW = max(1, clog2(NUM_PLAYERS)).
TOTAL_PAIRS, 8, pairs on the board; game ends when this many hits are counted; legal range 1..99.
TURN_SECONDS, 15, per-turn countdown start value; legal range 1..99.
CLK_HZ, 25000000, clock cycles per one-second tick.

Ports:
clk  in  1  system clock (vga_clk domain)
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; starts a new game from IDLE or DONE
match_valid  in  1  single-cycle pulse from the memory block; a pair of cards has been resolved
match_hit  in  1  qualifies match_valid; 1 = pair matched, 0 = mismatch
cur_player  out  PW  index of the active player
timer_tens  out  4  BCD tens digit of the remaining turn seconds
timer_units  out  4  BCD units digit of the remaining turn seconds
scores_bcd  out  8*NUM_PLAYERS  per-player score; player i occupies [8i+7:8i] as {tens,units}
pairs_found  out  7  binary count of matched pairs
turn_timeout  out  1  one-cycle pulse when the turn passes because the timer expired
game_done  out  1  high while in DONE
result_valid  out  1  high once the winner scan has completed
winner  out  PW  lowest-index player holding the maximum score
tie  out  1  set when more than one player holds the maximum score

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; cur_player=0, timer=BCD(TURN_SECONDS), all scores 0, pairs_found 0, prescaler 0, winner 0, all flags 0.
- State IDLE: outputs frozen; start -> PLAY.
- Entering PLAY: scores, pairs_found and cur_player are cleared; the timer is reloaded; the prescaler is cleared.
- Prescaler: counts 0..CLK_HZ-1 only in PLAY. sec_tick is asserted on the cycle the prescaler wraps.
- PLAY, sec_tick with timer > 0: BCD decrement. Units 0 borrows, so 10 becomes 09.
- PLAY, sec_tick with timer == 0:
  - cur_player advances; NUM_PLAYERS-1 wraps to 0.
  - The timer is reloaded.
  - turn_timeout pulses for 1 cycle.
  - A timer value of 00 is therefore displayed for one full second.
- PLAY, match_valid && match_hit:
  - score[cur_player] is incremented in BCD (09 -> 10), saturating at 99.
  - pairs_found is incremented.
  - cur_player is unchanged; the timer and prescaler reload.
- PLAY, match_valid && !match_hit: cur_player advances with wrap; the timer and prescaler reload.
- Simultaneous match_valid and sec_tick: match_valid has priority. The tick is discarded and turn_timeout does not pulse.
- When the post-increment pairs_found == TOTAL_PAIRS: next state DONE. The timer holds its value.
- start during PLAY is ignored. match_valid outside PLAY is ignored.
- DONE winner scan (sequential):
  - On entry: index=0, max=score[0], winner=0, tie=0, result_valid=0.
  - Each cycle index i = 1..NUM_PLAYERS-1 is compared as an 8-bit value; BCD ordering equals binary ordering.
  - greater -> max=score[i], winner=i, tie=0.
  - equal -> tie=1.
  - result_valid goes to 1 NUM_PLAYERS cycles after entry and holds.
- DONE: game_done=1; start -> PLAY (new game). A start arriving mid-scan aborts the scan and clears result_valid.
- Reset asserted mid-game returns to the reset values immediately. There is no partial state retention.
- Latency: a score or player change is visible on the outputs 1 cycle after the match_valid edge.

Test Plan:
- Use CLK_HZ=4, NUM_PLAYERS=3, TURN_SECONDS=12, TOTAL_PAIRS=3 for all scenarios.
- Reset then start -> cur_player=0, timer 1/2. After 4 cycles the timer reads 1/1; after 12 ticks it reads 0/0; the next tick gives turn_timeout=1, cur_player=1, timer 1/2.
- Timeouts from player 2 -> cur_player wraps to 0.
- Three mismatches -> cur_player sequence 1,2,0; scores stay 0.
- match_valid hit for player 0, then hit, then miss -> scores_bcd[7:0]=8'h02 and cur_player=1. The timer reloads to 12 after each event.
- match_valid hit asserted on the same cycle as a timer-zero sec_tick -> score increments, cur_player unchanged, no turn_timeout, timer=12.
- Hits: player 0 twice, then a miss, then player 1 once:
  - After the third hit: pairs_found=3 and game_done=1.
  - 3 cycles later: result_valid=1, winner=0, tie=0.
- Tie game (pairs 1/1/1) -> winner=0, tie=1.
- start in DONE -> all scores clear and the game returns to PLAY.
- Pull rst low mid-turn with scores nonzero -> all outputs return to their reset values asynchronously, before the next clk edge.
